// File: rtl/apb_pkg.sv
// Shared state encoding and default geometry for the APB master controller.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } apb_state_t;

    localparam int DEF_NUM_SLAVES = 2;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_SEL_W      = 1;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: counts up while enabled and saturates at TIMEOUT.
// expired_o flags the cycle in which the count has reached TIMEOUT.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != TERM_CNT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == TERM_CNT);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: takes one request at a time, runs SETUP/ACCESS on the
// decoded slave and returns a single-cycle response (data, or error on timeout/bad index).
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// SETUP  | psel asserted for the decoded slave, penable low
// ACCESS | penable high, waiting for the selected pready or timeout
// DECERR | index out of range, respond with error next cycle
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SEL_W      = DEF_SEL_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [SEL_W+ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic                         rsp_err,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [NUM_SLAVES-1:0]        pready_in,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata_in
);

    localparam int REQ_W = SEL_W + ADDR_W;

    apb_state_t              state_q;
    logic [SEL_W-1:0]        idx_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_W-1:0]       paddr_q;
    logic [DATA_W-1:0]       pwdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [DATA_W-1:0]       rsp_rdata_q;

    logic [SEL_W-1:0]        req_idx;
    logic                    req_idx_ok;
    logic [NUM_SLAVES-1:0]   req_onehot;
    logic                    sel_pready;
    logic [DATA_W-1:0]       sel_prdata;
    logic                    accept_good;
    logic                    tmr_enable;
    logic                    tmr_expired;

    assign req_idx    = req_addr[REQ_W-1:ADDR_W];
    assign req_idx_ok = (int'(req_idx) < NUM_SLAVES);

    // Request decode uses the incoming index; pready/prdata use the latched one.
    always_comb begin
        req_onehot = '0;
        sel_pready = 1'b0;
        sel_prdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(req_idx) == i) begin
                req_onehot[i] = 1'b1;
            end
            if (int'(idx_q) == i) begin
                sel_pready = pready_in[i];
                sel_prdata = prdata_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept_good = (state_q == IDLE) && req_valid && req_idx_ok;
    assign tmr_enable  = (state_q == SETUP) || (state_q == ACCESS);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk      (pclk),
        .preset    (preset),
        .clear_i   (accept_good),
        .enable_i  (tmr_enable),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        pwrite_q <= req_write;
                        paddr_q  <= req_addr[ADDR_W-1:0];
                        pwdata_q <= req_wdata;
                        idx_q    <= req_idx;
                        if (req_idx_ok) begin
                            psel_q  <= req_onehot;
                            state_q <= SETUP;
                        end else begin
                            state_q <= DECERR;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout landing in the same cycle.
                    if (sel_pready) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : sel_prdata;
                        state_q     <= IDLE;
                    end else if (tmr_expired) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                DECERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
